imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Instruction-memory responder for the 5-stage CPU's fetch port. It serves one word per cycle
//  on a fixed 1-cycle read latency against the CPU's word-address output.
//  It also accepts a byte-stream program load (host/UART side). Bytes are packed big-endian
//  into words and written into the array. The CPU is held in reset until the load completes.
//  Sits between the CPU's inst_mem_rd_addr_to_instmem/instruction_i pair and the board loader.
// PARAMETERS
//  DEPTH_WORDS  64            instruction words stored (power of 2)
//  ADDR_W       6             log2(DEPTH_WORDS)
//  OOR_WORD     32'h00000000  word returned for out-of-range fetch (sll $0,$0,0 = NOP)
//  HOLD_CYCLES  2             cycles cpu_hold_o stays high after load commit
// PORTS
//  clk             in   1   clock; all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  fetch_addr_i    in   32  word address from CPU (byte PC >> 2)
//  instruction_o   out  32  fetched word, valid 1 cycle after fetch_addr_i
//  load_start_i    in   1   1-cycle pulse: begin program load
//  load_valid_i    in   1   load_byte_i valid this cycle
//  load_byte_i     in   8   program byte, MSB-first within each word
//  load_end_i      in   1   1-cycle pulse: last byte already sent (or sent this cycle)
//  load_ready_o    out  1   responder accepts a byte this cycle
//  cpu_hold_o      out  1   drives the CPU's rst_n low (hold) while high
//  load_err_o      out  1   sticky: byte dropped because array full
//  words_loaded_o  out  ADDR_W+1  words written by the last/current load
// BEHAVIOUR
//  Reset is async, active-low. Values during reset:
//   - instruction_o=OOR_WORD, load_ready_o=0, cpu_hold_o=1, load_err_o=0, words_loaded_o=0.
//   - state=IDLE, byte_cnt=0, wr_ptr=0. Array contents are not reset.
//  FSM:
//   IDLE  : cpu_hold_o=1. load_start_i -> LOAD. After reset, IDLE -> SERVE when load_start_i is
//           not seen for 1 cycle (the prior array image runs).
//   SERVE : cpu_hold_o=0. load_start_i -> LOAD.
//   LOAD  : cpu_hold_o=1, load_ready_o=1. load_start_i is ignored.
//   FLUSH : one cycle; writes a pending partial word, then -> RELEASE.
//   RELEASE: cpu_hold_o=1 for HOLD_CYCLES cycles, then -> SERVE.
//  Fetch (SERVE and RELEASE):
//   - instruction_o <= (fetch_addr_i[31:ADDR_W]==0) ? mem[fetch_addr_i[ADDR_W-1:0]] : OOR_WORD.
//   - No wrap-around; address >= DEPTH_WORDS returns OOR_WORD.
//  Fetch in LOAD/FLUSH/IDLE: instruction_o <= OOR_WORD.
//  LOAD entry:
//   - wr_ptr=0, byte_cnt=0, words_loaded_o=0, load_err_o cleared.
//   - The assembly register is cleared to 0.
//  Byte accept (load_valid_i & load_ready_o):
//   - The byte goes into slot byte_cnt; slot 0 is [31:24], slot 3 is [7:0].
//   - byte_cnt increments mod 4.
//   - On the 4th byte, mem[wr_ptr] <= assembled word the same edge; wr_ptr++, words_loaded_o++.
//   - The assembly register clears after the write.
//  Full: when wr_ptr==DEPTH_WORDS, accepted bytes are discarded, load_err_o <= 1.
//   - load_ready_o stays 1 so the host never deadlocks.
//  load_end_i with load_valid_i in the same cycle: the byte is accepted first, then -> FLUSH.
//  FLUSH: if byte_cnt!=0 and not full, write the partial word zero-padded in the low bytes and
//   increment words_loaded_o. Otherwise there is no write.
//  Read/write same address same cycle cannot occur: writes happen only in LOAD/FLUSH.
//  Reset mid-load: the FSM aborts to IDLE. Words already written stay in the array; the rest
//   keeps old contents.
// TESTING
//  T1: reset, load 8 bytes 20 08 00 05 AC 03 00 03, end -> mem[0]=20080005, mem[1]=AC030003,
//      words_loaded_o=2, cpu_hold_o low exactly 2 cycles after FLUSH.
//  T2: SERVE, fetch_addr_i=1 at cycle n -> instruction_o=AC030003 at n+1.
//      fetch_addr_i=64 -> 00000000.
//  T3: load 5 bytes 11 22 33 44 55, load_end_i with the 5th byte -> mem[1]=55000000,
//      words_loaded_o=2, no load_err_o.
//  T4: load 65 full words (260 bytes) into DEPTH 64 -> words_loaded_o=64, load_err_o=1.
//      mem[63] holds word 63; word 64 is dropped.
//  T5: assert rst_n low after 6 bytes, then release -> state IDLE, cpu_hold_o=1.
//      mem[0] keeps word 0, load_err_o=0.
//  T6: load_start_i pulse during LOAD is ignored -> wr_ptr continues (no restart to 0).

Source files
------------

// File: rtl/imem_fetch_responder_if.sv
// Bundles the responder's fetch port and byte-stream program-load port.
// master: CPU fetch side plus host loader; slave: the responder itself.
interface imem_fetch_responder_if #(
    parameter int ADDR_W = 6
);
    logic [31:0]     fetch_addr_i;
    logic [31:0]     instruction_o;
    logic            load_start_i;
    logic            load_valid_i;
    logic [7:0]      load_byte_i;
    logic            load_end_i;
    logic            load_ready_o;
    logic            cpu_hold_o;
    logic            load_err_o;
    logic [ADDR_W:0] words_loaded_o;

    modport master (
        output fetch_addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
        input  instruction_o, load_ready_o, cpu_hold_o, load_err_o, words_loaded_o
    );

    modport slave (
        input  fetch_addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
        output instruction_o, load_ready_o, cpu_hold_o, load_err_o, words_loaded_o
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction memory for the CPU fetch port with a 1-cycle read latency.
// A host byte stream is packed big-endian into words and written into the
// array; the CPU is held in reset while loading and briefly afterwards.
module imem_fetch_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_W      = 6,
    parameter logic [31:0] OOR_WORD    = 32'h0000_0000,
    parameter int          HOLD_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    imem_fetch_responder_if.slave bus
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W + 1)'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_LOAD,
        S_FLUSH,
        S_RELEASE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     asm_word;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] wr_ptr;
    logic [HC_W-1:0] hold_cnt;
    logic            err_q;

    logic            load_entry;
    logic            byte_acc;
    logic            full;
    logic            word_done;
    logic            flush_wr;
    logic            fetch_en;
    logic            fetch_in_range;

    // Place a byte into its big-endian slot: slot 0 is the most significant byte.
    function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                                input logic [1:0]  slot,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (slot)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    assign load_entry     = ((state == S_IDLE) || (state == S_SERVE)) && bus.load_start_i;
    assign byte_acc       = (state == S_LOAD) && bus.load_valid_i;
    assign full           = (wr_ptr == FULL_PTR);
    assign word_done      = byte_acc && !full && (byte_cnt == 2'd3);
    assign flush_wr       = (state == S_FLUSH) && (byte_cnt != 2'd0) && !full;
    assign fetch_en       = (state == S_SERVE) || (state == S_RELEASE);
    assign fetch_in_range = (bus.fetch_addr_i[31:ADDR_W] == '0);

    assign bus.load_ready_o   = (state == S_LOAD);
    assign bus.cpu_hold_o     = (state != S_SERVE);
    assign bus.load_err_o     = err_q;
    assign bus.words_loaded_o = wr_ptr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; a start pulse while loading is deliberately ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = bus.load_start_i ? S_LOAD : S_SERVE;
            S_SERVE:   if (bus.load_start_i) state_nxt = S_LOAD;
            S_LOAD:    if (bus.load_end_i) state_nxt = S_FLUSH;
            S_FLUSH:   state_nxt = S_RELEASE;
            S_RELEASE: if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) state_nxt = S_SERVE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Load bookkeeping: byte slot, write pointer, sticky overflow flag, release timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            wr_ptr   <= '0;
            err_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            if (load_entry) begin
                byte_cnt <= 2'd0;
                wr_ptr   <= '0;
                err_q    <= 1'b0;
            end else if (byte_acc) begin
                if (full) begin
                    err_q <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
                end
            end else if (flush_wr) begin
                wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
            end

            if (state == S_FLUSH)        hold_cnt <= '0;
            else if (state == S_RELEASE) hold_cnt <= hold_cnt + HC_W'(1);
        end
    end

    // Word assembly register; emptied at load start and after each completed word.
    always_ff @(posedge clk) begin
        if (load_entry) begin
            asm_word <= 32'h0;
        end else if (byte_acc && !full) begin
            if (byte_cnt == 2'd3) asm_word <= 32'h0;
            else                  asm_word <= insert_byte(asm_word, byte_cnt, bus.load_byte_i);
        end
    end

    // Array write: full words as the 4th byte lands, zero-padded partial word on flush.
    always_ff @(posedge clk) begin
        if (word_done)
            mem[wr_ptr[ADDR_W-1:0]] <= insert_byte(asm_word, 2'd3, bus.load_byte_i);
        else if (flush_wr)
            mem[wr_ptr[ADDR_W-1:0]] <= asm_word;
    end

    // Registered fetch; addresses past the array return the NOP word, no wrap-around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.instruction_o <= OOR_WORD;
        else if (fetch_en && fetch_in_range)
            bus.instruction_o <= mem[bus.fetch_addr_i[ADDR_W-1:0]];
        else
            bus.instruction_o <= OOR_WORD;
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed load/fetch scenarios, a fetch
// vector table, and random loads/fetches against a word-packing model.
module tb_imem_fetch_responder;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int HOLD   = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_fetch_responder_if #(.ADDR_W(ADDR_W)) bus ();

    imem_fetch_responder #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (ADDR_W),
        .OOR_WORD   (32'h0000_0000),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    int          exp_words;
    bit          exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bytes pack MSB-first into words, capped at DEPTH words; anything beyond is lost.
    task automatic model_load(input logic [7:0] q[$]);
        int n;
        int nw;
        logic [31:0] w;
        n  = q.size();
        nw = (n + 3) / 4;
        if (nw > DEPTH) nw = DEPTH;
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * i + b < n) w[31 - 8 * b -: 8] = q[4 * i + b];
            ref_mem[i] = w;
            known[i]   = 1'b1;
        end
        exp_words = nw;
        exp_err   = (n > 4 * DEPTH);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.fetch_addr_i = addr;
        tick();
        check(name, bus.instruction_o, exp);
    endtask

    task automatic do_load(input logic [7:0] q[$], input bit end_with_last,
                           input int stray_start_at, input bit gaps);
        int k;
        bus.fetch_addr_i = 32'h0;
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        check("ready_in_load", bus.load_ready_o, 1);
        check("hold_in_load", bus.cpu_hold_o, 1);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            bus.load_valid_i = 1'b1;
            bus.load_byte_i  = q[i];
            if (i == stray_start_at) bus.load_start_i = 1'b1;
            if (end_with_last && i == q.size() - 1) bus.load_end_i = 1'b1;
            tick();
            bus.load_valid_i = 1'b0;
            bus.load_start_i = 1'b0;
            bus.load_end_i   = 1'b0;
            if (i < 8) check("fetch_oor_in_load", bus.instruction_o, 32'h0);
        end
        if (!end_with_last) begin
            bus.load_end_i = 1'b1;
            tick();
            bus.load_end_i = 1'b0;
        end
        check("ready_low_flush", bus.load_ready_o, 0);
        check("hold_in_flush", bus.cpu_hold_o, 1);
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.cpu_hold_o && k < 20);
        check("hold_release_cycles", k, HOLD + 1);
        model_load(q);
        check("words_loaded", bus.words_loaded_o, exp_words);
        check("load_err", bus.load_err_o, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [6];
        logic [7:0]  q[$];
        logic [31:0] a;
        logic [31:0] e;
        int          n;

        vecs[0] = '{32'd1,          32'hAC03_0003};
        vecs[1] = '{32'd0,          32'h2008_0005};
        vecs[2] = '{32'd64,         32'h0};
        vecs[3] = '{32'd65,         32'h0};
        vecs[4] = '{32'hFFFF_FFFF,  32'h0};
        vecs[5] = '{32'h4000_0001,  32'h0};
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        bus.fetch_addr_i = 32'h0;
        bus.load_start_i = 1'b0;
        bus.load_valid_i = 1'b0;
        bus.load_byte_i  = 8'h0;
        bus.load_end_i   = 1'b0;
        rst_n = 1'b0;
        #23;
        check("rst_instr", bus.instruction_o, 32'h0);
        check("rst_ready", bus.load_ready_o, 0);
        check("rst_hold", bus.cpu_hold_o, 1);
        check("rst_err", bus.load_err_o, 0);
        check("rst_words", bus.words_loaded_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("idle_hold", bus.cpu_hold_o, 1);
        tick();
        check("idle_to_serve", bus.cpu_hold_o, 0);

        // T1: two-word load
        q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h03, 8'h00, 8'h03};
        do_load(q, 1'b0, -1, 1'b1);

        // T2: fetch vector table
        for (int i = 0; i < 6; i++) fetch(vecs[i].addr, vecs[i].exp, "fetch_vec");

        // T3: partial last word, end with the last byte
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_load(q, 1'b1, -1, 1'b0);
        fetch(32'd0, ref_mem[0], "t3_word0");
        fetch(32'd1, 32'h5500_0000, "t3_word1");

        // T6: stray start during load must not restart
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        do_load(q, 1'b0, 5, 1'b0);
        fetch(32'd0, 32'hAABB_CCDD, "t6_word0");
        fetch(32'd1, 32'h0102_0304, "t6_word1");

        // T4: overflow by one word
        q = {};
        for (int i = 0; i < 260; i++) q.push_back(8'($urandom));
        do_load(q, 1'b0, -1, 1'b0);
        fetch(32'd63, ref_mem[63], "t4_word63");
        fetch(32'd64, 32'h0, "t4_oor64");

        // T5: reset in the middle of a load
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_byte_i  = q[i];
            tick();
        end
        bus.load_valid_i = 1'b0;
        ref_mem[0] = {q[0], q[1], q[2], q[3]};
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_hold", bus.cpu_hold_o, 1);
        check("t5_rst_err", bus.load_err_o, 0);
        check("t5_rst_words", bus.words_loaded_o, 0);
        check("t5_rst_ready", bus.load_ready_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t5_idle_hold", bus.cpu_hold_o, 1);
        tick();
        check("t5_serve", bus.cpu_hold_o, 0);
        fetch(32'd0, ref_mem[0], "t5_word0_kept");
        fetch(32'd1, ref_mem[1], "t5_word1_old");

        // Random fetches across the whole image and beyond it
        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            e = (a < DEPTH) ? ref_mem[a[ADDR_W-1:0]] : 32'h0;
            fetch(a, e, "rand_fetch");
        end

        // Random short loads then full read-back of written words
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 23);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_load(q, 1'($urandom_range(0, 1)), -1, 1'b1);
            for (int w = 0; w < exp_words; w++) fetch(32'(w), ref_mem[w], "rand_load_fetch");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
